// File: rtl/data_mem_responder_pkg.sv
// Shared constants and decode helpers for the data-memory responder and its timer.
package data_mem_responder_pkg;

  localparam logic [31:0] RAM_BASE_DEF    = 32'h0000_0000;
  localparam logic [31:0] PERIPH_BASE_DEF = 32'h4000_0000;

  localparam logic [31:0] OFF_TH     = 32'h0000_0000;
  localparam logic [31:0] OFF_TL     = 32'h0000_0004;
  localparam logic [31:0] OFF_TCON   = 32'h0000_0008;
  localparam logic [31:0] OFF_LED    = 32'h0000_000C;
  localparam logic [31:0] OFF_SWITCH = 32'h0000_0010;

  localparam int TCON_EN = 0;  // timer run
  localparam int TCON_IE = 1;  // interrupt enable on reload
  localparam int TCON_IF = 2;  // interrupt flag, drives irq

  typedef enum logic [2:0] {
    TGT_NONE,
    TGT_RAM,
    TGT_TH,
    TGT_TL,
    TGT_TCON,
    TGT_LED,
    TGT_SWITCH
  } tgt_e;

  function automatic tgt_e periph_sel(input logic [31:0] off);
    case (off)
      OFF_TH:     return TGT_TH;
      OFF_TL:     return TGT_TL;
      OFF_TCON:   return TGT_TCON;
      OFF_LED:    return TGT_LED;
      OFF_SWITCH: return TGT_SWITCH;
      default:    return TGT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dm_timer.sv
// Reloading 32-bit up-counter (TH reload value, TL count, TCON control) with sticky interrupt flag.
module dm_timer
  import data_mem_responder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_th,
  input  logic        wr_tl,
  input  logic        wr_tcon,
  input  logic [31:0] wdata,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        irq
);

  logic       ovf;
  logic [2:0] tcon_nxt;

  // A software TL write pre-empts the reload, so it also suppresses the overflow event.
  always_comb begin
    ovf      = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF) && !wr_tl;
    tcon_nxt = wr_tcon ? wdata[2:0] : tcon;
    if (ovf && tcon_nxt[TCON_IE])
      tcon_nxt[TCON_IF] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
    end else begin
      if (wr_th)
        th <= wdata;
      if (wr_tl)
        tl <= wdata;
      else if (tcon[TCON_EN])
        tl <= (tl == 32'hFFFF_FFFF) ? th : tl + 32'd1;
      tcon <= tcon_nxt;
    end
  end

  assign irq = tcon[TCON_IF];

endmodule

// File: rtl/data_mem_responder.sv
// Single-cycle data-memory responder: word RAM plus timer/LED/switch registers,
// registered pulse/err/rdata one cycle after each request.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          DEPTH       = 256,
  parameter logic [31:0] RAM_BASE    = RAM_BASE_DEF,
  parameter logic [31:0] PERIPH_BASE = PERIPH_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  switch,
  output logic [31:0] rdata,
  output logic        pulse,
  output logic        err,
  output logic [7:0]  led,
  output logic        irq
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH) << 2;

  logic [31:0]   ram [DEPTH];
  logic [31:0]   ram_off;
  logic [31:0]   per_off;
  logic [AW-1:0] idx;
  tgt_e          tgt;
  logic          req;
  logic          reject;
  logic          wr_ok;
  logic [31:0]   rd_val;
  logic [31:0]   th;
  logic [31:0]   tl;
  logic [2:0]    tcon;

  // Decode: RAM window first, then the peripheral block; anything else is a miss.
  always_comb begin
    ram_off = addr - RAM_BASE;
    per_off = addr - PERIPH_BASE;
    idx     = ram_off[AW+1:2];
    if ({1'b0, ram_off} < RAM_BYTES)
      tgt = TGT_RAM;
    else
      tgt = periph_sel(per_off);
    req    = read | write;
    reject = (read & write) | (addr[1:0] != 2'b00) | (tgt == TGT_NONE)
           | (write & (tgt == TGT_SWITCH));
    wr_ok  = write & !reject;
    case (tgt)
      TGT_RAM:    rd_val = ram[idx];
      TGT_TH:     rd_val = th;
      TGT_TL:     rd_val = tl;
      TGT_TCON:   rd_val = {29'd0, tcon};
      TGT_LED:    rd_val = {24'd0, led};
      TGT_SWITCH: rd_val = {24'd0, switch};
      default:    rd_val = '0;
    endcase
  end

  dm_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .wr_th   (wr_ok && (tgt == TGT_TH)),
    .wr_tl   (wr_ok && (tgt == TGT_TL)),
    .wr_tcon (wr_ok && (tgt == TGT_TCON)),
    .wdata   (wdata),
    .th      (th),
    .tl      (tl),
    .tcon    (tcon),
    .irq     (irq)
  );

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (reset && wr_ok && (tgt == TGT_RAM))
      ram[idx] <= wdata;
  end

  // Response stage: registered one cycle after the request edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pulse <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
      led   <= '0;
    end else begin
      pulse <= req;
      err   <= req & reject;
      if (req)
        rdata <= (reject || write) ? 32'd0 : rd_val;
      if (wr_ok && (tgt == TGT_LED))
        led <= wdata[7:0];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench with a response scoreboard for data_mem_responder.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        read;
  logic        write;
  logic [7:0]  switch;
  logic [31:0] rdata;
  logic        pulse;
  logic        err;
  logic [7:0]  led;
  logic        irq;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
    logic        chk;
    string       tag;
  } exp_t;

  exp_t sb[$];

  data_mem_responder dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .wdata  (wdata),
    .read   (read),
    .write  (write),
    .switch (switch),
    .rdata  (rdata),
    .pulse  (pulse),
    .err    (err),
    .led    (led),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Scoreboard: every negedge either expects a response or expects silence.
  always @(negedge clk) begin
    logic exp_p;
    exp_t e;
    exp_p = (sb.size() > 0) && (sb[0].due == cyc);
    checks++;
    assert (pulse === exp_p) else begin
      errors++;
      $error("FAIL pulse[%s] got %0b want %0b", (sb.size() > 0) ? sb[0].tag : "idle", pulse, exp_p);
    end
    if (exp_p) begin
      e = sb.pop_front();
      checks++;
      assert (err === e.err) else begin
        errors++;
        $error("FAIL err[%s] got %0b want %0b", e.tag, err, e.err);
      end
      if (e.chk) begin
        checks++;
        assert (rdata === e.rdata) else begin
          errors++;
          $error("FAIL rdata[%s] got %h want %h", e.tag, rdata, e.rdata);
        end
      end
    end else if ((sb.size() > 0) && (sb[0].due < cyc)) begin
      e = sb.pop_front();
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s got %h want %h", tag, obs, expv);
    end
  endtask

  task automatic do_req(input string tag, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic e_err, input logic [31:0] e_rd, input logic chk);
    exp_t e;
    @(posedge clk);
    #2;
    read  = rd;
    write = wr;
    addr  = a;
    wdata = d;
    e.due = cyc + 1; e.err = e_err; e.rdata = e_rd; e.chk = chk; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk);
    #2;
    read  = 1'b0;
    write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wdata = '0; switch = 8'h00;
    #3;
    check("reset_rdata", rdata, 32'd0);
    check("reset_pulse", {31'd0, pulse}, 32'd0);
    check("reset_err",   {31'd0, err},   32'd0);
    check("reset_led",   {24'd0, led},   32'd0);
    check("reset_irq",   {31'd0, irq},   32'd0);
    #9 reset = 1'b1;

    // Basic RAM write then read
    do_req("wr_0x10", 0, 1, 32'h10, 32'hDEAD_BEEF, 0, 32'd0, 1);
    do_req("rd_0x10", 1, 0, 32'h10, 32'd0,         0, 32'hDEAD_BEEF, 1);

    // Rejections and boundaries
    do_req("rw_both",   1, 1, 32'h10,        32'h0,  1, 32'd0, 1);
    do_req("misalign",  1, 0, 32'h12,        32'h0,  1, 32'd0, 1);
    do_req("unmapped",  1, 0, 32'h8000_0000, 32'h0,  1, 32'd0, 1);
    do_req("rd_after",  1, 0, 32'h10,        32'h0,  0, 32'hDEAD_BEEF, 1);
    do_req("wr_switch", 0, 1, 32'h4000_0010, 32'h55, 1, 32'd0, 1);
    do_req("ram_last",  1, 0, 32'h3FC,       32'h0,  0, 32'd0, 0);
    do_req("ram_past",  1, 0, 32'h400,       32'h0,  1, 32'd0, 1);
    do_req("per_past",  1, 0, 32'h4000_0014, 32'h0,  1, 32'd0, 1);

    // Read-before-write across consecutive requests
    do_req("wr20_a", 0, 1, 32'h20, 32'h11, 0, 32'd0,  1);
    do_req("rd20_a", 1, 0, 32'h20, 32'h0,  0, 32'h11, 1);
    do_req("wr20_b", 0, 1, 32'h20, 32'h22, 0, 32'd0,  1);
    do_req("rd20_b", 1, 0, 32'h20, 32'h0,  0, 32'h22, 1);

    // Switch and LED registers
    switch = 8'hA5;
    do_req("rd_switch", 1, 0, 32'h4000_0010, 32'h0,         0, 32'h0000_00A5, 1);
    do_req("wr_led",    0, 1, 32'h4000_000C, 32'h1234_5678, 0, 32'd0,         1);
    do_req("rd_led",    1, 0, 32'h4000_000C, 32'h0,         0, 32'h0000_0078, 1);
    idle();
    @(posedge clk);
    @(negedge clk);
    check("led_port",   {24'd0, led}, 32'h78);
    check("rdata_hold", rdata, 32'h78);

    // Timer reload with interrupt
    do_req("wr_th",   0, 1, 32'h4000_0000, 32'hFFFF_FFF0, 0, 32'd0, 1);
    do_req("wr_tl",   0, 1, 32'h4000_0004, 32'hFFFF_FFFE, 0, 32'd0, 1);
    do_req("wr_tcon", 0, 1, 32'h4000_0008, 32'h3,         0, 32'd0, 1);
    do_req("tl_1",    1, 0, 32'h4000_0004, 32'h0,         0, 32'hFFFF_FFFE, 1);
    do_req("tl_2",    1, 0, 32'h4000_0004, 32'h0,         0, 32'hFFFF_FFFF, 1);
    do_req("tl_3",    1, 0, 32'h4000_0004, 32'h0,         0, 32'hFFFF_FFF0, 1);
    do_req("tcon_if", 1, 0, 32'h4000_0008, 32'h0,         0, 32'h7,         1);
    idle();
    @(negedge clk);
    check("irq_set", {31'd0, irq}, 32'd1);
    do_req("clr_if", 0, 1, 32'h4000_0008, 32'h3, 0, 32'd0, 1);
    idle();
    @(negedge clk);
    check("irq_clr", {31'd0, irq}, 32'd0);

    // Software TL write on the overflow edge
    do_req("stop",     0, 1, 32'h4000_0008, 32'h0,         0, 32'd0, 1);
    do_req("th_100",   0, 1, 32'h4000_0000, 32'h100,       0, 32'd0, 1);
    do_req("tl_max",   0, 1, 32'h4000_0004, 32'hFFFF_FFFF, 0, 32'd0, 1);
    do_req("run",      0, 1, 32'h4000_0008, 32'h3,         0, 32'd0, 1);
    do_req("tl_5",     0, 1, 32'h4000_0004, 32'h5,         0, 32'd0, 1);
    do_req("tl_is5",   1, 0, 32'h4000_0004, 32'h0,         0, 32'h5, 1);
    do_req("tcon_3",   1, 0, 32'h4000_0008, 32'h0,         0, 32'h3, 1);
    idle();
    @(negedge clk);
    check("irq_noovf", {31'd0, irq}, 32'd0);

    // Reset while a read is in flight
    @(posedge clk);
    #2;
    read = 1'b1; write = 1'b0; addr = 32'h10;
    @(posedge clk);
    #1;
    reset = 1'b0;
    read  = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    check("led_after_rst", {24'd0, led}, 32'd0);
    do_req("tcon_rst", 1, 0, 32'h4000_0008, 32'h0, 0, 32'd0,         1);
    do_req("led_rst",  1, 0, 32'h4000_000C, 32'h0, 0, 32'd0,         1);
    do_req("ram_kept", 1, 0, 32'h10,        32'h0, 0, 32'hDEAD_BEEF, 1);
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit RAM words; SHALL be a power of two.
REQ-002 Parameter RAM_BASE, default 32'h0000_0000, byte address of RAM word 0.
REQ-003 Parameter PERIPH_BASE, default 32'h4000_0000, byte address of first peripheral register.
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-005 reset  input  1  reset is asynchronous and active-low.
REQ-006 addr  input  32  byte address of the request.
REQ-007 wdata  input  32  write data.
REQ-008 read  input  1  read request, sampled at rising clk.
REQ-009 write  input  1  write request, sampled at rising clk.
REQ-010 switch  input  8  external switch levels, read-only register.
REQ-011 rdata  output  32  read response data.
REQ-012 pulse  output  1  one-cycle completion strobe for every accepted or rejected request.
REQ-013 err  output  1  qualifies pulse; high = request rejected.
REQ-014 led  output  8  LED register value.
REQ-015 irq  output  1  timer interrupt level.

Function
REQ-016 Request SHALL be taken at any rising clk where read|write=1; one request per cycle, no stall, back-to-back allowed.
REQ-017 pulse, err, rdata SHALL be registered: valid exactly 1 cycle after the request edge, pulse high for 1 cycle per request.
REQ-018 RAM hit: addr in [RAM_BASE, RAM_BASE+4*DEPTH); index = (addr-RAM_BASE)>>2.
REQ-019 Peripheral map: +0x00 TH (rw32), +0x04 TL (rw32), +0x08 TCON (rw, bits[2:0]), +0x0C LED (rw, bits[7:0]), +0x10 SWITCH (ro, bits[7:0]); unused bits read 0.
REQ-020 Reject (err=1, pulse=1, rdata=0, no state change) when: read&write both 1; addr[1:0]!=0; addr outside RAM and peripheral map; write to SWITCH.
REQ-021 Accepted write: target updated at the request edge; rdata=0 on the response cycle.
REQ-022 Accepted read: rdata = target value before any same-edge update (read-before-write across consecutive requests to same address gives old then new).
REQ-023 Cycles with no request: pulse=0, err=0, rdata holds last value.
REQ-024 Timer: when TCON[0]=1, TL SHALL increment by 1 every cycle; when TL=32'hFFFF_FFFF, next TL=TH and, if TCON[1]=1, TCON[2] set to 1.
REQ-025 irq SHALL equal TCON[2]; TCON[2] cleared only by a software write to TCON with bit 2 = 0.
REQ-026 Simultaneous software write to TL and timer increment/reload: software write wins.
REQ-027 Simultaneous TCON write and overflow: written value wins except TCON[2] SHALL be set if overflow occurs with TCON[1] (new value) = 1.
REQ-028 TH write does not affect TL until next reload.

Reset
REQ-029 On reset low, asynchronously: rdata=0, pulse=0, err=0, TH=0, TL=0, TCON=0, LED=0, irq=0.
REQ-030 RAM contents SHALL NOT be reset; reads before any write return undefined data, err=0.
REQ-031 A request in flight when reset asserts SHALL produce no pulse after reset releases.
REQ-032 First request SHALL be accepted at the first rising clk with reset high.

Structure
REQ-033 Shared package SHALL hold peripheral offsets, TCON bit indices, and default RAM_BASE/PERIPH_BASE constants.
REQ-034 Timer (TH/TL/TCON, irq) SHALL be one sub-module, dm_timer; RAM and decode stay in data_mem_responder.

Verification
REQ-035 Write 0x0000_0010 <- 32'hDEAD_BEEF, then read 0x10 -> pulse each cycle after, err=0, second response rdata=32'hDEAD_BEEF.
REQ-036 read=write=1 at 0x10; misaligned read 0x12; read 0x8000_0000 -> three pulses with err=1, rdata=0, RAM word 4 unchanged.
REQ-037 TH=32'hFFFF_FFF0, TL=32'hFFFF_FFFE, TCON=3'b011 -> TL=FFFF_FFFF next cycle, then TL=FFFF_FFF0 and irq=1; write TCON=3'b011 -> irq=0.
REQ-038 Same edge as TL overflow, write TL=5 -> TL=5, no reload, TCON[2] unchanged.
REQ-039 switch=8'hA5, read 0x4000_0010 -> rdata=32'h0000_00A5; write 0x4000_000C <- 32'h1234_5678 -> led=8'h78.
REQ-040 Assert reset one cycle after a read request -> pulse never seen; after release TCON=0, led=0, RAM word 4 retains 32'hDEAD_BEEF.
